// File: rtl/cpu_phase_ctrl.sv
// cpu_phase_ctrl: single-clock instruction phase sequencer producing one-cycle enable strobes.
// Optional feature macro PHASE_CTRL_PERF_EN: when defined, instr_cnt/stall_cnt are live
// counters; when undefined both outputs are tied to zero.
module cpu_phase_ctrl #(
    parameter int FETCH_WAIT = 1,
    parameter int MEM_WAIT   = 1,
    parameter int MD_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        is_mul_div,
    input  logic        is_mem,
    input  logic        alu_complete,
    output logic        en_fetch,
    output logic        en_reg_rd,
    output logic        en_alu,
    output logic        md_start,
    output logic        en_mem,
    output logic        en_wb,
    output logic        busy,
    output logic [2:0]  phase,
    output logic        md_timeout,
    output logic [31:0] instr_cnt,
    output logic [31:0] stall_cnt
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXEC    = 3'd3,
        MD_WAIT = 3'd4,
        MEM     = 3'd5,
        WB      = 3'd6
    } state_t;

    localparam int FM_WAIT  = FETCH_WAIT > MEM_WAIT ? FETCH_WAIT : MEM_WAIT;
    localparam int MAX_WAIT = FM_WAIT > MD_TIMEOUT ? FM_WAIT : MD_TIMEOUT;
    localparam int CW       = $clog2(MAX_WAIT + 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          md_flag, mem_flag;
    logic          first, fetch_done, mem_done, md_expired;

    // cnt holds the 1-based cycle index within the current state
    assign first      = cnt == CW'(1);
    assign fetch_done = cnt == CW'(FETCH_WAIT);
    assign mem_done   = cnt == CW'(MEM_WAIT);
    assign md_expired = cnt == CW'(MD_TIMEOUT);

    // State register and in-state cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= CW'(1);
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state selection; the cycle counter restarts on every state change
    always_comb begin
        state_n = IDLE;
        case (state)
            IDLE:    state_n = run ? FETCH : IDLE;
            FETCH:   state_n = fetch_done ? DECODE : FETCH;
            DECODE:  state_n = EXEC;
            EXEC:    state_n = md_flag ? MD_WAIT : (mem_flag ? MEM : WB);
            MD_WAIT: state_n = (alu_complete || md_expired) ? WB : MD_WAIT;
            MEM:     state_n = mem_done ? WB : MEM;
            WB:      state_n = run ? FETCH : IDLE;
            default: state_n = IDLE;
        endcase
        cnt_n = (state_n != state || state == IDLE) ? CW'(1) : cnt + CW'(1);
    end

    // Decoder flags captured in DECODE; sticky timeout unless completion arrives the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            md_flag    <= 1'b0;
            mem_flag   <= 1'b0;
            md_timeout <= 1'b0;
        end else begin
            if (state == DECODE) begin
                md_flag  <= is_mul_div;
                mem_flag <= is_mem;
            end
            if (state == MD_WAIT && !alu_complete && md_expired)
                md_timeout <= 1'b1;
        end
    end

    // Strobes decoded purely from registered state and cycle counter
    always_comb begin
        en_fetch  = state == FETCH && first;
        en_reg_rd = state == DECODE;
        en_alu    = state == EXEC;
        md_start  = state == EXEC && md_flag;
        en_mem    = state == MEM && first;
        en_wb     = state == WB;
        busy      = state != IDLE;
        phase     = state;
    end

`ifdef PHASE_CTRL_PERF_EN
    // Retired-instruction and mul/div stall counters, wrapping silently
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (state == WB)
                instr_cnt <= instr_cnt + 32'd1;
            if (state == MD_WAIT)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    assign instr_cnt = '0;
    assign stall_cnt = '0;
`endif
endmodule
